// File: rtl/sel_accum_pair_param.sv
// sel_accum_pair_param: selector-stepped x/y accumulator pair with iteration bound,
// wrap/saturate arithmetic, sticky overflow and a built-in sum-invariant monitor.
module sel_accum_pair_param #(
  parameter int WIDTH    = 15,
  parameter int STEP_A   = 1,
  parameter int STEP_B   = 2,
  parameter int MAX_ITER = 1000,
  parameter int SATURATE = 0,
  localparam int ITW     = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             selector,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [ITW-1:0]   iter,
  output logic             done,
  output logic             ovf,
  output logic             inv_ok
);
  typedef enum logic {RUN, DONE} state_t;
  localparam logic [WIDTH-1:0] SA = WIDTH'(STEP_A);
  localparam logic [WIDTH-1:0] SB = WIDTH'(STEP_B);
  state_t state, state_nx;
  logic [WIDTH-1:0] shadow, step_x, step_y, x_nx, y_nx, xy_sum;
  logic [WIDTH:0] x_sum, y_sum;
  logic [ITW-1:0] iter_nx;
  logic upd;
  always_comb begin
    upd = state == RUN && en && !clr;
    step_x = selector ? SA : SB;
    step_y = selector ? SB : SA;
    x_sum = {1'b0, x} + {1'b0, step_x};
    y_sum = {1'b0, y} + {1'b0, step_y};
    x_nx = (SATURATE != 0 && x_sum[WIDTH]) ? '1 : x_sum[WIDTH-1:0];
    y_nx = (SATURATE != 0 && y_sum[WIDTH]) ? '1 : y_sum[WIDTH-1:0];
    iter_nx = iter + 1'b1;
    state_nx = clr ? RUN : (upd && iter_nx == ITW'(MAX_ITER)) ? DONE : state;
    done = state == DONE;
    xy_sum = x + y;
    // once a saturating register clamps, the sum relation is no longer expected to hold
    inv_ok = xy_sum == shadow || (SATURATE != 0 && ovf);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= RUN;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst || clr) begin
      x <= '0;
      y <= '0;
      iter <= '0;
      shadow <= '0;
      ovf <= 1'b0;
    end else if (upd) begin
      x <= x_nx;
      y <= y_nx;
      iter <= iter_nx;
      shadow <= shadow + SA + SB;
      ovf <= ovf | x_sum[WIDTH] | y_sum[WIDTH];
    end
endmodule

// File: tb/tb_sel_accum_pair_param.sv
// tb_sel_accum_pair_param: four parameterisations share one stimulus stream; a
// reference model feeds a scoreboard queue that is drained after every edge.
module tb_sel_accum_pair_param;
  logic clk = 0, rst = 0, en = 0, clr = 0, selector = 0;
  always #5 clk = ~clk;

  logic [14:0] d0_x, d0_y, d3_x, d3_y;
  logic [3:0]  d1_x, d1_y, d2_x, d2_y;
  logic [9:0]  d0_it, d1_it, d2_it;
  logic [2:0]  d3_it;
  logic [3:0]  dn, ov, ok;

  sel_accum_pair_param u0 (.clk(clk), .rst(rst), .en(en), .clr(clr), .selector(selector),
    .x(d0_x), .y(d0_y), .iter(d0_it), .done(dn[0]), .ovf(ov[0]), .inv_ok(ok[0]));
  sel_accum_pair_param #(.WIDTH(4)) u1 (.clk(clk), .rst(rst), .en(en), .clr(clr), .selector(selector),
    .x(d1_x), .y(d1_y), .iter(d1_it), .done(dn[1]), .ovf(ov[1]), .inv_ok(ok[1]));
  sel_accum_pair_param #(.WIDTH(4), .SATURATE(1)) u2 (.clk(clk), .rst(rst), .en(en), .clr(clr), .selector(selector),
    .x(d2_x), .y(d2_y), .iter(d2_it), .done(dn[2]), .ovf(ov[2]), .inv_ok(ok[2]));
  sel_accum_pair_param #(.MAX_ITER(5)) u3 (.clk(clk), .rst(rst), .en(en), .clr(clr), .selector(selector),
    .x(d3_x), .y(d3_y), .iter(d3_it), .done(dn[3]), .ovf(ov[3]), .inv_ok(ok[3]));

  logic [14:0] ox [4], oy [4];
  logic [9:0]  oit [4];
  assign ox[0] = d0_x;         assign oy[0] = d0_y;         assign oit[0] = d0_it;
  assign ox[1] = {11'b0, d1_x}; assign oy[1] = {11'b0, d1_y}; assign oit[1] = d1_it;
  assign ox[2] = {11'b0, d2_x}; assign oy[2] = {11'b0, d2_y}; assign oit[2] = d2_it;
  assign ox[3] = d3_x;         assign oy[3] = d3_y;         assign oit[3] = {7'b0, d3_it};

  typedef struct packed {
    logic [14:0] x, y;
    logic [9:0]  it;
    logic dn, ov;
  } exp_t;
  exp_t q[$];

  int compared = 0, mismatched = 0;
  int pw [4] = '{15, 4, 4, 15};
  int psat [4] = '{0, 0, 1, 0};
  int pmi [4] = '{1000, 1000, 1000, 5};
  int mx [4], my [4], mit [4];
  bit mdn [4], mov [4];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic madd(int i, inout int v, input int s);
    int lim = 1 << pw[i];
    v = v + s;
    if (v >= lim) begin
      mov[i] = 1;
      v = psat[i] != 0 ? lim - 1 : v - lim;
    end
  endtask

  task automatic mzero();
    for (int i = 0; i < 4; i++) begin
      mx[i] = 0; my[i] = 0; mit[i] = 0; mdn[i] = 0; mov[i] = 0;
    end
  endtask

  task automatic push();
    for (int i = 0; i < 4; i++)
      q.push_back('{x: 15'(mx[i]), y: 15'(my[i]), it: 10'(mit[i]), dn: mdn[i], ov: mov[i]});
  endtask

  task automatic drain(string tag);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e = q.pop_front();
      chk($sformatf("%s.u%0d.x", tag, i), 32'(ox[i]), 32'(e.x));
      chk($sformatf("%s.u%0d.y", tag, i), 32'(oy[i]), 32'(e.y));
      chk($sformatf("%s.u%0d.iter", tag, i), 32'(oit[i]), 32'(e.it));
      chk($sformatf("%s.u%0d.done", tag, i), 32'(dn[i]), 32'(e.dn));
      chk($sformatf("%s.u%0d.ovf", tag, i), 32'(ov[i]), 32'(e.ov));
      chk($sformatf("%s.u%0d.inv_ok", tag, i), 32'(ok[i]), 32'd1);
    end
  endtask

  task automatic cycle(string tag, bit e, bit c, bit s);
    en = e; clr = c; selector = s;
    for (int i = 0; i < 4; i++)
      if (c) begin
        mx[i] = 0; my[i] = 0; mit[i] = 0; mdn[i] = 0; mov[i] = 0;
      end else if (e && !mdn[i]) begin
        madd(i, mx[i], s ? 1 : 2);
        madd(i, my[i], s ? 2 : 1);
        mit[i]++;
        if (mit[i] == pmi[i]) mdn[i] = 1;
      end
    push();
    @(posedge clk);
    #1;
    drain(tag);
  endtask

  initial begin
    mzero();
    push();
    #2 drain("reset");
    rst = 1;
    for (int k = 0; k < 3; k++) cycle("p1", 1, 0, 1);
    chk("p1_x", 32'(d0_x), 3); chk("p1_y", 32'(d0_y), 6); chk("p1_iter", 32'(d0_it), 3);
    cycle("p2clr", 0, 1, 0);
    for (int k = 0; k < 4; k++) cycle("p2", 1, 0, (k % 2) == 0);
    chk("p2_x", 32'(d0_x), 6); chk("p2_y", 32'(d0_y), 6); chk("p2_iter", 32'(d0_it), 4);
    for (int k = 0; k < 5; k++) cycle("p2hold", 0, 0, k[0]);
    chk("p2hold_x", 32'(d0_x), 6); chk("p2hold_iter", 32'(d0_it), 4);
    cycle("p3clr", 0, 1, 1);
    for (int k = 1; k <= 9; k++) begin
      cycle("p3", 1, 0, 1);
      if (k == 5) begin
        chk("max_done", 32'(dn[3]), 1); chk("max_iter", 32'(d3_it), 5);
      end
      if (k == 7) begin
        chk("wrap7_x", 32'(d1_x), 7); chk("wrap7_y", 32'(d1_y), 14); chk("wrap7_ovf", 32'(ov[1]), 0);
      end
      if (k == 8) begin
        chk("wrap8_x", 32'(d1_x), 8); chk("wrap8_y", 32'(d1_y), 0); chk("wrap8_ovf", 32'(ov[1]), 1);
        chk("sat8_x", 32'(d2_x), 8); chk("sat8_y", 32'(d2_y), 15); chk("sat8_ovf", 32'(ov[2]), 1);
      end
    end
    chk("sat9_x", 32'(d2_x), 9); chk("sat9_y", 32'(d2_y), 15);
    chk("frozen_x", 32'(d3_x), 5); chk("frozen_y", 32'(d3_y), 10); chk("frozen_iter", 32'(d3_it), 5);
    cycle("p4clr", 1, 1, 1);
    chk("clr_done", 32'(dn[3]), 0); chk("clr_iter", 32'(d3_it), 0);
    cycle("p4", 1, 0, 0);
    chk("after_clr_x", 32'(d3_x), 2); chk("after_clr_iter", 32'(d3_it), 1);
    cycle("p5clr", 0, 1, 0);
    for (int k = 0; k < 3; k++) cycle("p5", 1, 0, 1);
    #2 rst = 0;
    mzero();
    push();
    #1 drain("async_rst");
    chk("async_x", 32'(d0_x), 0); chk("async_iter", 32'(d0_it), 0);
    rst = 1;
    cycle("p5rel", 1, 0, 1);
    chk("restart_x", 32'(d0_x), 1); chk("restart_iter", 32'(d0_it), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
